// File: rtl/reg_wb_arbiter.sv
// Arbitrates the ALU (req0) and load (req1) writebacks onto the single register-file write port.
// Optional macro REG_WB_ARB_RR_EN swaps fixed priority plus starvation override for round-robin arbitration.
module reg_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        starve_cnt
);

  logic              both_valid;
  logic              same_addr;
  logic              prefer0;
  logic              grant0;
  logic              grant1;
  logic              handshake;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign both_valid = req0_valid && req1_valid;
  assign same_addr  = (req0_addr == req1_addr);

`ifdef REG_WB_ARB_RR_EN
  logic rr_ptr;

  // On contention the pointer moves to whichever side just lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (both_valid) begin
      rr_ptr <= grant0;
    end
  end

  assign prefer0    = !rr_ptr;
  assign starve_cnt = 4'd0;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (req0_valid && !grant0) begin
      starve_q <= (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end else begin
      starve_q <= 4'd0;
    end
  end

  assign prefer0    = (starve_q == STARVE_LIM);
  assign starve_cnt = starve_q;
`endif

  // Equal destinations always go to the load so its value lands first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (both_valid) begin
        if (!same_addr && prefer0) grant0 = 1'b1;
        else                       grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign handshake  = grant0 || grant1;
  assign win_addr   = grant0 ? req0_addr : req1_addr;
  assign win_data   = grant0 ? req0_data : req1_data;

  // x0 writes are accepted but leave the address/data registers untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= handshake && (win_addr != '0);
      if (handshake && (win_addr != '0)) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: stimulus pushes expected register-port contents, a monitor pops and compares.
`timescale 1ns/1ps
module tb_reg_wb_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef REG_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        starve_cnt;

  reg_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  // Reference model state: starvation count, preference pointer, register-port contents.
  int  m_starve = 0;
  bit  m_ptr    = 1'b0;
  wr_t m_reg    = '{we: 1'b0, addr: '0, data: '0};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic modelReset();
    m_starve = 0;
    m_ptr    = 1'b0;
    m_reg    = '{we: 1'b0, addr: '0, data: '0};
    exp_q.delete();
  endtask

  // Drives one cycle of requests, checks grants, and queues the expected register contents.
  task automatic applyStimulus(input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                               output int g);
    int eg;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    if (v0 && v1) begin
      if (a0 == a1)  eg = 2;
      else if (RR)   eg = (m_ptr == 1'b0) ? 1 : 2;
      else           eg = (m_starve == STARVE_MAX) ? 1 : 2;
    end else if (v0) eg = 1;
    else if (v1)     eg = 2;
    else             eg = 0;
    checkOutput("ready", {62'd0, req1_ready, req0_ready},
                {62'd0, (eg == 2) ? 1'b1 : 1'b0, (eg == 1) ? 1'b1 : 1'b0});
    checkOutput("starve_cnt", 64'(starve_cnt), RR ? 64'd0 : 64'(m_starve));
    m_reg.we = 1'b0;
    if (eg != 0) begin
      if (((eg == 1) ? a0 : a1) != 0) begin
        m_reg.we   = 1'b1;
        m_reg.addr = (eg == 1) ? a0 : a1;
        m_reg.data = (eg == 1) ? d0 : d1;
      end
    end
    exp_q.push_back(m_reg);
    if (v0 && eg != 1) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
    else               m_starve = 0;
    if (v0 && v1) m_ptr = (eg == 1);
    g = eg;
  endtask

  // Monitor: the register port presents a new value after every clock.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rf_we", 64'(rf_we), 64'(e.we));
        checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g, n, exp_g;
    bit p0, p1;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;

    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h2;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("reset_starve", 64'(starve_cnt), 64'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    modelReset();

    $display("[TB] single ALU write and x0 load write");
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, g);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, g);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);

    $display("[TB] starvation override");
    n = 0;
    g = 0;
    while (g != 1 && n < 20) begin
      applyStimulus(1, 5'd3, 32'hA0A0A0A0, 1, 5'd4, $urandom, g);
      n++;
    end
    checkOutput("starve_grant_cycle", 64'(n), RR ? 64'd1 : 64'(STARVE_MAX + 1));
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);

    $display("[TB] same-address conflict");
    n = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 5'd7, 32'h77777777, 1, 5'd7, $urandom, g);
      if (g == 1) n++;
    end
    checkOutput("same_addr_req0_grants", 64'(n), 64'd0);

    $display("[TB] async reset with a pending write");
    applyStimulus(1, 5'd9, 32'hCAFEF00D, 1, 5'd10, 32'h0BADF00D, g);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_rf_we", 64'(rf_we), 64'd0);
    checkOutput("async_rst_rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("async_rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    $display("[TB] continuous contention after reset");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 5'(11 + i), $urandom, 1, 5'(20 + i), $urandom, g);
      if (RR) exp_g = (i % 2 == 0) ? 1 : 2;
      else    exp_g = (i == STARVE_MAX) ? 1 : 2;
      checkOutput("contention_grant", 64'(g), 64'(exp_g));
    end
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);

    $display("[TB] randomized traffic");
    p0 = 1'b0; p1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; pa0 = 5'($urandom_range(0, 7)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; pa1 = 5'($urandom_range(0, 7)); pd1 = $urandom;
      end
      applyStimulus(p0, pa0, pd0, p1, pa1, pd1, g);
      if (g == 1) p0 = 1'b0;
      if (g == 2) p1 = 1'b0;
    end

    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    @(posedge clk);
    #2;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
